// File: rtl/dual_dispatch.sv
// Dual-issue in-order dispatch: 8-deep instruction queue, register renaming via status table, CDB retire/bypass.
// One-cycle issue latency after enqueue; inst_ready drops when the queue is full, stalls when the head station is busy.
module dual_dispatch #(
  parameter int QDEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [7:0]  rs_free,
  input  logic [11:0] outadd,
  input  logic [11:0] outmul,
  input  logic [11:0] outfetch,
  input  logic        rf_we,
  input  logic [3:0]  rf_addr,
  input  logic [7:0]  rf_wdata,
  output logic [15:0] instruction1,
  output logic [15:0] instruction2,
  output logic        send1,
  output logic        send2,
  output logic [1:0]  status_bus_tag1,
  output logic [1:0]  status_bus_tag2,
  output logic [11:0] reg_bus1,
  output logic [11:0] reg_bus2,
  output logic [11:0] opnd1_bus1,
  output logic [11:0] opnd1_bus2,
  output logic        illegal
);
  localparam int PW = $clog2(QDEPTH);

  typedef struct packed {
    logic [15:0] ins;
    logic [1:0]  st;
    logic [11:0] rb;
    logic [11:0] oa;
  } slot_t;

  logic [15:0]   r_q [QDEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic [7:0]    r_rf [16];
  logic [15:0]   r_busy;
  logic [2:0]    r_prod [16];

  logic [PW-1:0] w_head2;
  logic [15:0]   w_q1, w_q2;
  logic [3:0]    w_op1, w_op2;
  logic          w_issue1, w_issue2, w_drop1, w_s1_wr, w_s2_wr, w_enq;
  logic [1:0]    w_deq;
  logic [15:0]   w_hit;
  logic [7:0]    w_hval [16];
  logic [12:0]   w_a1, w_b1, w_a2, w_b2;
  slot_t         w_slot1, w_slot2;

  // Returns {virtual, tag[3:0], value[7:0]} for one source register.
  function automatic logic [12:0] f_opnd(input logic [3:0] r, input logic s1_wr, input logic [2:0] s1_op,
                                         input logic busy, input logic [2:0] prod, input logic hit,
                                         input logic [7:0] hval, input logic [7:0] rfv);
    if (s1_wr)     return {1'b1, 1'b0, s1_op, 8'h00};
    else if (hit)  return {1'b0, r, hval};
    else if (busy) return {1'b1, 1'b0, prod, 8'h00};
    else           return {1'b0, r, rfv};
  endfunction

  function automatic slot_t f_slot(input logic [15:0] q, input logic [12:0] oa, input logic [12:0] ob);
    slot_t s;
    s.ins = q;
    s.st  = 2'b00;
    s.rb  = '0;
    s.oa  = '0;
    if (q[15:14] == 2'b00) begin
      s.st = {oa[12], ob[12]};
      s.rb = ob[11:0];
      s.oa = oa[11:0];
    end else if (q[15:13] == 3'b011) begin
      s.st = {1'b0, ob[12]};
      s.rb = ob[11:0];
      if (ob[12]) s.ins[3:0] = ob[11:8];
    end
    return s;
  endfunction

  assign w_head2    = r_head + PW'(1);
  assign w_q1       = r_q[r_head];
  assign w_q2       = r_q[w_head2];
  assign w_op1      = w_q1[15:12];
  assign w_op2      = w_q2[15:12];
  assign w_issue1   = (r_count != '0) && !w_op1[3] && rs_free[w_op1[2:0]];
  assign w_drop1    = (r_count != '0) && w_op1[3];
  assign w_issue2   = w_issue1 && (r_count > (PW+1)'(1)) && !w_op2[3] && (w_op2 != w_op1) && rs_free[w_op2[2:0]];
  assign w_deq      = (w_issue1 || w_drop1) ? (w_issue2 ? 2'd2 : 2'd1) : 2'd0;
  assign w_s1_wr    = w_issue1 && (w_op1[2:1] != 2'b11);
  assign w_s2_wr    = w_issue2 && (w_op2[2:1] != 2'b11);
  assign inst_ready = (r_count != (PW+1)'(QDEPTH));
  assign w_enq      = inst_valid && inst_ready;

  // Later assignment wins, so outadd has the highest bypass priority.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_hit[i]  = 1'b0;
      w_hval[i] = 8'h00;
      if (r_busy[i]) begin
        if (outfetch[11:8] != 4'hF && outfetch[11:8] == {1'b0, r_prod[i]}) begin
          w_hit[i] = 1'b1; w_hval[i] = outfetch[7:0];
        end
        if (outmul[11:8] != 4'hF && outmul[11:8] == {1'b0, r_prod[i]}) begin
          w_hit[i] = 1'b1; w_hval[i] = outmul[7:0];
        end
        if (outadd[11:8] != 4'hF && outadd[11:8] == {1'b0, r_prod[i]}) begin
          w_hit[i] = 1'b1; w_hval[i] = outadd[7:0];
        end
      end
    end
  end

  assign w_a1 = f_opnd(w_q1[7:4], 1'b0, 3'd0, r_busy[w_q1[7:4]], r_prod[w_q1[7:4]],
                       w_hit[w_q1[7:4]], w_hval[w_q1[7:4]], r_rf[w_q1[7:4]]);
  assign w_b1 = f_opnd(w_q1[3:0], 1'b0, 3'd0, r_busy[w_q1[3:0]], r_prod[w_q1[3:0]],
                       w_hit[w_q1[3:0]], w_hval[w_q1[3:0]], r_rf[w_q1[3:0]]);
  assign w_a2 = f_opnd(w_q2[7:4], w_s1_wr && (w_q1[11:8] == w_q2[7:4]), w_op1[2:0], r_busy[w_q2[7:4]],
                       r_prod[w_q2[7:4]], w_hit[w_q2[7:4]], w_hval[w_q2[7:4]], r_rf[w_q2[7:4]]);
  assign w_b2 = f_opnd(w_q2[3:0], w_s1_wr && (w_q1[11:8] == w_q2[3:0]), w_op1[2:0], r_busy[w_q2[3:0]],
                       r_prod[w_q2[3:0]], w_hit[w_q2[3:0]], w_hval[w_q2[3:0]], r_rf[w_q2[3:0]]);
  assign w_slot1 = f_slot(w_q1, w_a1, w_b1);
  assign w_slot2 = f_slot(w_q2, w_a2, w_b2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        r_rf[i]   <= 8'h00;
        r_prod[i] <= 3'd0;
      end
      instruction1    <= 16'hFFFF;
      instruction2    <= 16'hFFFF;
      send1           <= 1'b0;
      send2           <= 1'b0;
      status_bus_tag1 <= 2'b00;
      status_bus_tag2 <= 2'b00;
      reg_bus1        <= '0;
      reg_bus2        <= '0;
      opnd1_bus1      <= '0;
      opnd1_bus2      <= '0;
      illegal         <= 1'b0;
    end else begin
      if (w_enq) begin
        r_q[r_tail] <= inst_in;
        r_tail      <= r_tail + PW'(1);
      end
      r_head  <= r_head + PW'(w_deq);
      r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_deq);

      // Preload, then CDB retire, then rename: later writes take precedence.
      if (rf_we) r_rf[rf_addr] <= rf_wdata;
      for (int i = 0; i < 16; i++) begin
        if (w_hit[i]) begin
          r_busy[i] <= 1'b0;
          r_rf[i]   <= w_hval[i];
        end
      end
      if (w_s1_wr) begin
        r_busy[w_q1[11:8]] <= 1'b1;
        r_prod[w_q1[11:8]] <= w_op1[2:0];
      end
      if (w_s2_wr) begin
        r_busy[w_q2[11:8]] <= 1'b1;
        r_prod[w_q2[11:8]] <= w_op2[2:0];
      end

      send1   <= w_issue1;
      send2   <= w_issue2;
      illegal <= w_drop1 && (w_op1 != 4'hF);
      if (w_issue1) begin
        instruction1    <= w_slot1.ins;
        status_bus_tag1 <= w_slot1.st;
        reg_bus1        <= w_slot1.rb;
        opnd1_bus1      <= w_slot1.oa;
        if (w_issue2) begin
          instruction2    <= w_slot2.ins;
          status_bus_tag2 <= w_slot2.st;
          reg_bus2        <= w_slot2.rb;
          opnd1_bus2      <= w_slot2.oa;
        end else begin
          instruction2    <= 16'hFFFF;
          status_bus_tag2 <= 2'b00;
          reg_bus2        <= '0;
          opnd1_bus2      <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dual_dispatch.sv
// Directed bench for dual_dispatch: issue, rename, bypass, full queue, illegal/bubble, reset.
module tb_dual_dispatch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inst_in = 16'h0000;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [7:0]  rs_free = 8'h00;
  logic [11:0] outadd = 12'hFFF, outmul = 12'hFFF, outfetch = 12'hFFF;
  logic        rf_we = 1'b0;
  logic [3:0]  rf_addr = 4'h0;
  logic [7:0]  rf_wdata = 8'h00;
  logic [15:0] instruction1, instruction2;
  logic        send1, send2, illegal;
  logic [1:0]  status_bus_tag1, status_bus_tag2;
  logic [11:0] reg_bus1, reg_bus2, opnd1_bus1, opnd1_bus2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] list [9];
  logic saw_send;

  dual_dispatch #(.QDEPTH(8)) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .rs_free(rs_free), .outadd(outadd), .outmul(outmul), .outfetch(outfetch),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .instruction1(instruction1), .instruction2(instruction2), .send1(send1), .send2(send2),
    .status_bus_tag1(status_bus_tag1), .status_bus_tag2(status_bus_tag2),
    .reg_bus1(reg_bus1), .reg_bus2(reg_bus2), .opnd1_bus1(opnd1_bus1), .opnd1_bus2(opnd1_bus2),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic enq(input logic [15:0] ins);
    inst_valid = 1'b1;
    inst_in    = ins;
    tick();
    inst_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    list = '{16'h0123, 16'h1456, 16'h2789, 16'h3ABC, 16'h0D12, 16'h1E34, 16'h2F56, 16'h3078, 16'h0999};
    #2 rst = 1'b1;
    #2;
    check("rst_send1", {15'd0, send1}, 16'h0);
    check("rst_instr1", instruction1, 16'hFFFF);
    check("rst_instr2", instruction2, 16'hFFFF);
    check("rst_ready", {15'd0, inst_ready}, 16'h1);
    check("rst_regbus1", {4'd0, reg_bus1}, 16'h0);
    tick();
    rst = 1'b0;

    // Store reading a preloaded register.
    rs_free = 8'hFF;
    rf_we = 1'b1; rf_addr = 4'd3; rf_wdata = 8'h5A;
    inst_valid = 1'b1; inst_in = 16'h6203;
    tick();
    rf_we = 1'b0; inst_valid = 1'b0;
    tick();
    check("t1_send1", {15'd0, send1}, 16'h1);
    check("t1_instr1", instruction1, 16'h6203);
    check("t1_status1", {14'd0, status_bus_tag1}, 16'h0);
    check("t1_regbus1", {4'd0, reg_bus1}, 16'h035A);
    check("t1_send2", {15'd0, send2}, 16'h0);

    // Dual issue with same-cycle dependency on slot 1.
    rs_free = 8'h00;
    enq(16'h0712);
    enq(16'h6307);
    rs_free = 8'hFF;
    tick();
    check("t2_send1", {15'd0, send1}, 16'h1);
    check("t2_send2", {15'd0, send2}, 16'h1);
    check("t2_instr1", instruction1, 16'h0712);
    check("t2_opnd1", {4'd0, opnd1_bus1}, 16'h0100);
    check("t2_instr2", instruction2, 16'h6300);
    check("t2_status2", {14'd0, status_bus_tag2}, 16'h1);
    check("t2_regbus2", {4'd0, reg_bus2}, 16'h0000);

    // CDB bypass on the issue edge, then r7 is retired.
    enq(16'h6307);
    outadd = 12'h0C4;
    tick();
    outadd = 12'hFFF;
    check("t3_instr1", instruction1, 16'h6307);
    check("t3_status1", {14'd0, status_bus_tag1}, 16'h0);
    check("t3_regbus1", {4'd0, reg_bus1}, 16'h07C4);
    enq(16'h6307);
    tick();
    check("t3_retired_status", {14'd0, status_bus_tag1}, 16'h0);
    check("t3_retired_regbus", {4'd0, reg_bus1}, 16'h07C4);

    // Two loads on the same station serialize.
    rs_free = 8'h00;
    enq(16'h4012);
    enq(16'h4034);
    rs_free = 8'h10;
    tick();
    check("t4_a_send1", {15'd0, send1}, 16'h1);
    check("t4_a_send2", {15'd0, send2}, 16'h0);
    check("t4_a_instr1", instruction1, 16'h4012);
    check("t4_a_instr2", instruction2, 16'hFFFF);
    tick();
    check("t4_b_send1", {15'd0, send1}, 16'h1);
    check("t4_b_instr1", instruction1, 16'h4034);
    tick();
    check("hold_send1", {15'd0, send1}, 16'h0);
    check("hold_instr1", instruction1, 16'h4034);

    // Store reading r0 while the load on F0 is outstanding.
    rs_free = 8'hFF;
    enq(16'h6200);
    tick();
    check("t5_instr1", instruction1, 16'h6204);
    check("t5_status1", {14'd0, status_bus_tag1}, 16'h1);
    check("t5_regbus1", {4'd0, reg_bus1}, 16'h0400);

    // Illegal opcode then bubble.
    enq(16'h9123);
    enq(16'hF000);
    check("t6_illegal", {15'd0, illegal}, 16'h1);
    check("t6_ill_send1", {15'd0, send1}, 16'h0);
    tick();
    check("t6_bubble_illegal", {15'd0, illegal}, 16'h0);
    check("t6_bubble_send1", {15'd0, send1}, 16'h0);

    // Fill the queue, drop the ninth, then drain two per cycle.
    rs_free = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) check("full_ready_empty", {15'd0, inst_ready}, 16'h1);
      if (i == 8) check("full_ready_full", {15'd0, inst_ready}, 16'h0);
      inst_valid = 1'b1;
      inst_in    = list[i];
      tick();
    end
    inst_valid = 1'b0;
    rs_free = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d_send1", k), {15'd0, send1}, 16'h1);
      check($sformatf("drain%0d_send2", k), {15'd0, send2}, 16'h1);
      check($sformatf("drain%0d_instr1", k), instruction1, list[2*k]);
      check($sformatf("drain%0d_instr2", k), instruction2, list[2*k+1]);
    end
    tick();
    check("drain_empty_send1", {15'd0, send1}, 16'h0);
    check("drain_ready", {15'd0, inst_ready}, 16'h1);

    // Reset with five entries queued.
    rs_free = 8'h00;
    for (int i = 0; i < 5; i++) enq(list[i]);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_instr1", instruction1, 16'hFFFF);
    check("mid_rst_instr2", instruction2, 16'hFFFF);
    check("mid_rst_opnd1", {4'd0, opnd1_bus1}, 16'h0);
    check("mid_rst_ready", {15'd0, inst_ready}, 16'h1);
    tick();
    rst = 1'b0;
    rs_free = 8'hFF;
    saw_send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (send1 || send2) saw_send = 1'b1;
    end
    check("post_rst_no_send", {15'd0, saw_send}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
